cursor_select_ctrl: RTL and testbench

- Player-input sequencer for the checkers board.
- Converts the six push-buttons into cursor movement, piece selection and move commits.
- Owns cursor_loc and select_loc (display inputs), consumes the legal-move vector for the selected piece, and hands a committed move to the game-state logic via req/ack.
- Sits between the board buttons, the move generator/game FSM, and the display.

---
 rtl/checkers_pkg.sv | 48 ++++
 rtl/btn_debounce.sv | 55 +++++
 rtl/cursor_select_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cursor_select_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checkers_pkg.sv
// -----------------------------------------------------------------------------
// checkers_pkg
// Shared constants and types for the checkers board input path.
//   - Location encoding: 6 bits, {x[2:0], y[2:0]}, y = 7 is the top row.
//   - Serialized board square field: 3 bits per square, [2] occupied,
//     [1] red, [0] king.
//   - Legal-move vector: four 7-bit entries {valid, loc[5:0]}.
//   - Button indices into the active-low button bus.
//   - Sequencer FSM state type.
// -----------------------------------------------------------------------------
package checkers_pkg;

    localparam int unsigned LOC_W      = 6;
    localparam int unsigned NUM_SQ     = 64;
    localparam int unsigned SQ_W       = 3;
    localparam int unsigned SQ_OCC     = 2;
    localparam int unsigned SQ_RED     = 1;
    localparam int unsigned SQ_KING    = 0;

    localparam int unsigned LM_ENTRY_W = 7;
    localparam int unsigned LM_ENTRIES = 4;
    localparam int unsigned LM_VALID   = 6;

    localparam int unsigned NUM_BTN    = 6;
    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_ENTER  = 4;
    localparam int unsigned BTN_CANCEL = 5;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSelected = 2'd1,
        StCommit   = 2'd2,
        StLocked   = 2'd3
    } sel_state_e;

    // Coordinate step that saturates at the board edge instead of wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] v);
        return (v == 3'd0) ? v : v - 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stable-level debounce counter and press-pulse
// generator for one active-low push-button.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   i_btn_n  raw button, active-low
//   o_press  one-cycle pulse when the debounced level becomes pressed
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any bounce back to the accepted level restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/cursor_select_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_select_ctrl
// Player-input sequencer for the checkers board: turns debounced button
// presses into cursor movement, piece selection and move commits, and hands
// a committed move to the game logic through a move_req/move_ack handshake.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   btn_n[5:0]          raw buttons (up, down, left, right, enter, cancel)
//   serialized_board    3 bits per square {occ, red, king}
//   red_turn            side to move (1 = red)
//   legal_move          4 x {valid, loc} for the piece at select_loc
//   red_win, white_win  game-over flags
//   move_ack            game logic applied the pending move (pulse)
//   cursor_loc          cursor square {x, y}
//   select_loc          selected square, select_valid qualifies it
//   move_req            move pending, move_from/move_to describe it
//   locked              game over, input ignored until reset
// -----------------------------------------------------------------------------
module cursor_select_ctrl
    import checkers_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       btn_n,
    input  logic [191:0]     serialized_board,
    input  logic             red_turn,
    input  logic [27:0]      legal_move,
    input  logic             red_win,
    input  logic             white_win,
    input  logic             move_ack,
    output logic [5:0]       cursor_loc,
    output logic [5:0]       select_loc,
    output logic             select_valid,
    output logic             move_req,
    output logic [5:0]       move_from,
    output logic [5:0]       move_to,
    output logic             locked
);

    logic [NUM_BTN-1:0] w_press;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_btn_n(btn_n[g]),
            .o_press(w_press[g])
        );
    end

    sel_state_e   r_state;
    logic [5:0]   r_cursor;
    logic [5:0]   r_select;
    logic         r_select_valid;
    logic         r_move_req;
    logic [5:0]   r_from;
    logic [5:0]   r_to;
    logic         r_locked;
    logic [27:0]  r_legal;

    logic [NUM_SQ-1:0] w_occ;
    logic [NUM_SQ-1:0] w_red;
    logic              w_unused_king;
    logic              w_cur_own;
    logic              w_cur_legal;
    logic              w_win;
    logic              w_do_cancel;
    logic              w_do_enter;
    logic              w_do_move;
    logic [5:0]        w_cursor_mv;

    always_comb begin
        w_occ         = '0;
        w_red         = '0;
        w_unused_king = 1'b0;
        for (int i = 0; i < NUM_SQ; i++) begin
            w_occ[i]      = serialized_board[SQ_W*i + SQ_OCC];
            w_red[i]      = serialized_board[SQ_W*i + SQ_RED];
            w_unused_king = w_unused_king ^ serialized_board[SQ_W*i + SQ_KING];
        end
    end

    assign w_cur_own = w_occ[r_cursor] && (w_red[r_cursor] == red_turn);
    assign w_win     = red_win | white_win;

    // Uses the registered copy of legal_move, which lags select_loc by a cycle.
    always_comb begin
        w_cur_legal = 1'b0;
        for (int k = 0; k < LM_ENTRIES; k++) begin
            if (r_legal[LM_ENTRY_W*k + LM_VALID] &&
                (r_legal[LM_ENTRY_W*k +: LOC_W] == r_cursor)) begin
                w_cur_legal = 1'b1;
            end
        end
    end

    // One action per cycle: cancel > enter > up > down > left > right.
    always_comb begin
        w_do_cancel = w_press[BTN_CANCEL];
        w_do_enter  = w_press[BTN_ENTER] & ~w_press[BTN_CANCEL];
        w_do_move   = 1'b0;
        w_cursor_mv = r_cursor;
        if (!w_press[BTN_CANCEL] && !w_press[BTN_ENTER]) begin
            if (w_press[BTN_UP]) begin
                w_do_move   = 1'b1;
                w_cursor_mv = {r_cursor[5:3], sat_inc(r_cursor[2:0])};
            end else if (w_press[BTN_DOWN]) begin
                w_do_move   = 1'b1;
                w_cursor_mv = {r_cursor[5:3], sat_dec(r_cursor[2:0])};
            end else if (w_press[BTN_LEFT]) begin
                w_do_move   = 1'b1;
                w_cursor_mv = {sat_dec(r_cursor[5:3]), r_cursor[2:0]};
            end else if (w_press[BTN_RIGHT]) begin
                w_do_move   = 1'b1;
                w_cursor_mv = {sat_inc(r_cursor[5:3]), r_cursor[2:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= StIdle;
            r_cursor       <= '0;
            r_select       <= '0;
            r_select_valid <= 1'b0;
            r_move_req     <= 1'b0;
            r_from         <= '0;
            r_to           <= '0;
            r_locked       <= 1'b0;
            r_legal        <= '0;
        end else begin
            r_legal <= legal_move;
            unique case (r_state)
                StIdle: begin
                    if (w_win) begin
                        r_state        <= StLocked;
                        r_locked       <= 1'b1;
                        r_select_valid <= 1'b0;
                    end else if (w_do_enter) begin
                        if (w_cur_own) begin
                            r_select       <= r_cursor;
                            r_select_valid <= 1'b1;
                            r_state        <= StSelected;
                        end
                    end else if (w_do_move) begin
                        r_cursor <= w_cursor_mv;
                    end
                end
                StSelected: begin
                    if (w_win) begin
                        r_state        <= StLocked;
                        r_locked       <= 1'b1;
                        r_select_valid <= 1'b0;
                    end else if (w_do_cancel) begin
                        r_select_valid <= 1'b0;
                        r_state        <= StIdle;
                    end else if (w_do_enter) begin
                        if (r_cursor == r_select) begin
                            r_select_valid <= 1'b0;
                            r_state        <= StIdle;
                        end else if (w_cur_legal) begin
                            r_from     <= r_select;
                            r_to       <= r_cursor;
                            r_move_req <= 1'b1;
                            r_state    <= StCommit;
                        end else if (w_cur_own) begin
                            r_select <= r_cursor;
                        end
                    end else if (w_do_move) begin
                        r_cursor <= w_cursor_mv;
                    end
                end
                StCommit: begin
                    // A win raised mid-commit is only honoured once the move lands.
                    if (move_ack) begin
                        r_move_req     <= 1'b0;
                        r_select_valid <= 1'b0;
                        r_locked       <= w_win;
                        r_state        <= w_win ? StLocked : StIdle;
                    end
                end
                StLocked: begin
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cursor_loc   = r_cursor;
    assign select_loc   = r_select;
    assign select_valid = r_select_valid;
    assign move_req     = r_move_req;
    assign move_from    = r_from;
    assign move_to      = r_to;
    assign locked       = r_locked;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
module tb_cursor_select_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned HOLD = DB + 8;

    localparam int M_IDLE   = 0;
    localparam int M_SEL    = 1;
    localparam int M_COMMIT = 2;
    localparam int M_LOCK   = 3;

    localparam logic [5:0] K_UP     = 6'b000001;
    localparam logic [5:0] K_DOWN   = 6'b000010;
    localparam logic [5:0] K_LEFT   = 6'b000100;
    localparam logic [5:0] K_RIGHT  = 6'b001000;
    localparam logic [5:0] K_ENTER  = 6'b010000;
    localparam logic [5:0] K_CANCEL = 6'b100000;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   btn_n;
    logic [191:0] board;
    logic         red_turn;
    logic [27:0]  legal_move;
    logic         red_win;
    logic         white_win;
    logic         move_ack;
    logic [5:0]   cursor_loc;
    logic [5:0]   select_loc;
    logic         select_valid;
    logic         move_req;
    logic [5:0]   move_from;
    logic [5:0]   move_to;
    logic         locked;

    logic [27:0]  lm_table [64];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_x, m_y, m_st;
    logic [5:0] m_sel, m_from, m_to;
    bit         m_selv, m_req, m_lock;

    always #5 clk = ~clk;

    // Move generator stand-in: legal moves depend only on the selected square.
    always_comb legal_move = lm_table[select_loc];

    cursor_select_ctrl #(
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_n           (btn_n),
        .serialized_board(board),
        .red_turn        (red_turn),
        .legal_move      (legal_move),
        .red_win         (red_win),
        .white_win       (white_win),
        .move_ack        (move_ack),
        .cursor_loc      (cursor_loc),
        .select_loc      (select_loc),
        .select_valid    (select_valid),
        .move_req        (move_req),
        .move_from       (move_from),
        .move_to         (move_to),
        .locked          (locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0] ex, ey;
        ex = m_x[2:0];
        ey = m_y[2:0];
        chk({tag, ".cursor"}, 32'(cursor_loc), 32'({ex, ey}));
        chk({tag, ".sel_valid"}, 32'(select_valid), 32'(m_selv));
        if (m_selv) chk({tag, ".sel_loc"}, 32'(select_loc), 32'(m_sel));
        chk({tag, ".move_req"}, 32'(move_req), 32'(m_req));
        chk({tag, ".move_from"}, 32'(move_from), 32'(m_from));
        chk({tag, ".move_to"}, 32'(move_to), 32'(m_to));
        chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
    endtask

    function automatic bit own(input int loc);
        return board[3*loc + 2] && (board[3*loc + 1] == red_turn);
    endfunction

    function automatic bit is_legal(input logic [5:0] sel, input logic [5:0] cur);
        logic [27:0] v;
        logic [6:0]  e;
        v = lm_table[sel];
        for (int k = 0; k < 4; k++) begin
            e = v[7*k +: 7];
            if (e[6] && e[5:0] == cur) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_press(input logic [5:0] m);
        logic [5:0] cur;
        cur = 6'(m_x * 8 + m_y);
        if (m_st == M_LOCK || m_st == M_COMMIT) return;
        if (m[5]) begin
            if (m_st == M_SEL) begin
                m_selv = 0;
                m_st   = M_IDLE;
            end
            return;
        end
        if (m[4]) begin
            if (m_st == M_IDLE) begin
                if (own(int'(cur))) begin
                    m_sel = cur; m_selv = 1; m_st = M_SEL;
                end
            end else if (cur == m_sel) begin
                m_selv = 0; m_st = M_IDLE;
            end else if (is_legal(m_sel, cur)) begin
                m_from = m_sel; m_to = cur; m_req = 1; m_st = M_COMMIT;
            end else if (own(int'(cur))) begin
                m_sel = cur;
            end
            return;
        end
        if (m[0])      m_y = (m_y < 7) ? m_y + 1 : 7;
        else if (m[1]) m_y = (m_y > 0) ? m_y - 1 : 0;
        else if (m[2]) m_x = (m_x > 0) ? m_x - 1 : 0;
        else if (m[3]) m_x = (m_x < 7) ? m_x + 1 : 7;
    endtask

    task automatic press(input logic [5:0] m, input string tag);
        @(negedge clk) btn_n = ~m;
        repeat (HOLD) @(negedge clk);
        btn_n = '1;
        repeat (HOLD) @(negedge clk);
        model_press(m);
        check_all(tag);
    endtask

    task automatic ack(input string tag);
        @(negedge clk) move_ack = 1'b1;
        @(negedge clk) move_ack = 1'b0;
        if (m_st == M_COMMIT) begin
            m_req = 0; m_selv = 0;
            if (red_win || white_win) begin
                m_st = M_LOCK; m_lock = 1;
            end else begin
                m_st = M_IDLE;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic goto(input int x, input int y);
        for (int n = 0; n < 16 && m_x < x; n++) press(K_RIGHT, "goto");
        for (int n = 0; n < 16 && m_x > x; n++) press(K_LEFT, "goto");
        for (int n = 0; n < 16 && m_y < y; n++) press(K_UP, "goto");
        for (int n = 0; n < 16 && m_y > y; n++) press(K_DOWN, "goto");
    endtask

    task automatic set_sq(input int loc, input bit occ, input bit red);
        board[3*loc +: 3] = {occ, red, 1'b0};
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; btn_n = '1; move_ack = 0; red_win = 0; white_win = 0;
        m_x = 0; m_y = 0; m_st = M_IDLE; m_sel = 0; m_from = 0; m_to = 0;
        m_selv = 0; m_req = 0; m_lock = 0;
        repeat (3) @(negedge clk);
        check_all({tag, ".in_reset"});
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        logic [5:0] mask;
        int         r, sx, sy, lx, ly;
        logic [6:0] ent;

        rst = 1'b1; btn_n = '1; board = '0; red_turn = 1'b1;
        red_win = 0; white_win = 0; move_ack = 0;
        for (int i = 0; i < 64; i++) lm_table[i] = '0;

        do_reset("reset");

        // Held up button: exactly one step, no auto-repeat.
        @(negedge clk) btn_n = ~K_UP;
        repeat (2*DB + 2) @(negedge clk);
        m_y = 1;
        check_all("hold_up");
        repeat (4*DB) @(negedge clk);
        check_all("hold_no_repeat");
        btn_n = '1;
        repeat (HOLD) @(negedge clk);

        // Short glitch is filtered.
        btn_n = ~K_UP;
        repeat (2) @(negedge clk);
        btn_n = '1;
        repeat (HOLD) @(negedge clk);
        check_all("glitch");

        // Saturation at top and left edges.
        for (int i = 0; i < 8; i++) press(K_UP, "sat_up");
        press(K_LEFT, "sat_left");

        // Selection ownership.
        goto(1, 1);
        red_turn = 1'b1;
        set_sq(9, 1, 0);
        press(K_ENTER, "enter_white_piece");
        set_sq(9, 1, 1);
        press(K_ENTER, "enter_red_piece");
        chk("sel_is_9", 32'(select_loc), 32'd9);

        // Commit to a legal square, arrows during commit, then ack.
        lm_table[9] = {1'b1, 6'd18, 21'd0};
        goto(2, 2);
        press(K_ENTER, "commit");
        chk("commit_req", 32'(move_req), 32'd1);
        press(K_UP, "commit_hold_up");
        press(K_RIGHT, "commit_hold_right");
        ack("commit_ack");
        ack("stray_ack");

        // Enter on non-legal empty square, then cancel.
        goto(1, 1);
        press(K_ENTER, "reselect9");
        goto(3, 3);
        press(K_ENTER, "enter_empty27");
        press(K_CANCEL, "cancel");

        // Cancel beats enter in the same cycle.
        goto(1, 1);
        press(K_ENTER, "sel9_again");
        goto(2, 2);
        press(K_ENTER | K_CANCEL, "cancel_beats_enter");

        // Randomised phase against the model.
        for (int i = 0; i < 64; i++) begin
            set_sq(i, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
            sx = i / 8; sy = i % 8;
            lm_table[i] = '0;
            for (int k = 0; k < 4; k++) begin
                lx = sx + int'($urandom_range(0, 4)) - 2;
                ly = sy + int'($urandom_range(0, 4)) - 2;
                if (lx < 0) lx = 0;
                if (lx > 7) lx = 7;
                if (ly < 0) ly = 0;
                if (ly > 7) ly = 7;
                ent = {1'($urandom_range(0, 1)), 6'(lx * 8 + ly)};
                lm_table[i][7*k +: 7] = ent;
            end
        end
        red_turn = 1'($urandom_range(0, 1));
        for (int s = 0; s < 70; s++) begin
            r = int'($urandom_range(0, 11));
            if (m_st == M_COMMIT && r < 6) begin
                ack("rnd_ack");
            end else if (r == 11) begin
                ack("rnd_stray_ack");
            end else begin
                if (r <= 3)      mask = 6'(1 << r);
                else if (r <= 7) mask = K_ENTER;
                else if (r == 8) mask = K_CANCEL;
                else             mask = 6'($urandom_range(1, 63));
                press(mask, "rnd");
            end
        end

        // Win during commit only locks after ack.
        do_reset("reset2");
        board = '0;
        set_sq(9, 1, 1);
        red_turn = 1'b1;
        lm_table[9] = {1'b1, 6'd18, 21'd0};
        goto(1, 1);
        press(K_ENTER, "w_sel9");
        goto(2, 2);
        press(K_ENTER, "w_commit");
        @(negedge clk) white_win = 1'b1;
        repeat (3) @(negedge clk);
        check_all("win_in_commit");
        ack("win_ack_lock");
        press(K_DOWN, "locked_down");

        // Win while selected locks immediately.
        do_reset("reset3");
        goto(1, 1);
        press(K_ENTER, "l_sel9");
        @(negedge clk) white_win = 1'b1;
        repeat (3) @(negedge clk);
        m_st = M_LOCK; m_selv = 0; m_lock = 1;
        check_all("win_in_selected");
        press(K_UP, "locked_up");
        press(K_ENTER, "locked_enter");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
